// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and the byte-enable helper for the data memory LSU.
// Pure types and functions; no timing or flow control of its own.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  typedef struct packed {
    logic  we;
    size_e size;
    logic  uns;
  } req_ctl_t;

  localparam int MAX_LANES = 64;

  // Big-endian: byte offset 0 is the top lane (lanes-1); lane 0 holds the LSBs.
  function automatic logic [MAX_LANES-1:0] be_mask(input size_e size, input int unsigned off,
                                                   input int unsigned lanes);
    logic [MAX_LANES-1:0] m;
    case (size)
      SZ_BYTE: m = MAX_LANES'(1) << (lanes - 1 - off);
      SZ_HALF: m = MAX_LANES'(3) << (lanes - 2 - off);
      SZ_WORD: m = (MAX_LANES'(1) << lanes) - MAX_LANES'(1);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x DATA_W storage, per-lane write enables, registered read (data valid after the read edge).
// No reset on contents; no flow control, the caller owns sequencing.
module dmem_array #(
  parameter  int DATA_W      = 32,
  parameter  int DEPTH_WORDS = 256,
  localparam int BYTES       = DATA_W / 8,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx,
  input  logic              wr_en,
  input  logic [BYTES-1:0]  be,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wr_dat[i*8 +: 8];
      end
    end
    if (rd_en) rd_dat <= mem[idx];
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed big-endian data memory with load/store front-end; response valid 2 edges after acceptance.
// One request in flight: req_ready low from acceptance until the response handshake, rsp_* held while rsp_ready is low.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_WORDS);

  state_e            state;
  req_ctl_t          ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W-1:0] word_a;
  logic [ADDR_W-1:0] off_a;
  int unsigned       off;
  logic              err;
  logic              acc;
  logic [BYTES-1:0]  be;
  logic [DATA_W-1:0] wr_dat;
  logic [DATA_W-1:0] rd_dat;
  logic [DATA_W-1:0] ld_dat;
  logic [7:0]        b8;
  logic [15:0]       h16;

  assign word_a    = addr_q / BYTES_A;
  assign off_a     = addr_q % BYTES_A;
  assign off       = 32'(off_a);
  assign req_ready = (state == S_IDLE) && !rst;
  assign acc       = (state == S_ACCESS) && !err;
  assign be        = BYTES'(be_mask(ctl_q.size, off, BYTES));

  always_comb begin
    case (ctl_q.size)
      SZ_HALF: err = off_a[0];
      SZ_WORD: err = (off_a != '0);
      SZ_RSVD: err = 1'b1;
      default: err = 1'b0;
    endcase
    if (word_a >= DEPTH_A) err = 1'b1;
  end

  // Store data is shifted into the lanes the mask selects; bits above the access size fall off.
  always_comb begin
    case (ctl_q.size)
      SZ_BYTE: wr_dat = DATA_W'(wdata_q[7:0]) << (8 * (BYTES - 1 - off));
      SZ_HALF: wr_dat = DATA_W'(wdata_q[15:0]) << (8 * (BYTES - 2 - off));
      default: wr_dat = wdata_q;
    endcase
  end

  always_comb begin
    b8  = 8'(rd_dat >> (8 * (BYTES - 1 - off)));
    h16 = 16'(rd_dat >> (8 * (BYTES - 2 - off)));
    case (ctl_q.size)
      SZ_BYTE: ld_dat = ctl_q.uns ? DATA_W'(b8)  : {{(DATA_W-8){b8[7]}}, b8};
      SZ_HALF: ld_dat = ctl_q.uns ? DATA_W'(h16) : {{(DATA_W-16){h16[15]}}, h16};
      default: ld_dat = rd_dat;
    endcase
  end

  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .idx    (word_a[IDX_W-1:0]),
    .wr_en  (acc && ctl_q.we && !rst),
    .be     (be),
    .wr_dat (wr_dat),
    .rd_en  (acc && !ctl_q.we),
    .rd_dat (rd_dat)
  );

  // RESP spends its first cycle capturing the array read into the output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            ctl_q   <= '{we: req_we, size: size_e'(req_size), uns: req_unsigned};
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: state <= S_RESP;
        S_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || ctl_q.we) ? '0 : ld_dat;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: scoreboard of expected {err, rdata} per request.
// Covers extension, misalignment, range, backpressure and reset in ACCESS/RESP.
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  data_memory_lsu #(.DATA_W(32), .DEPTH_WORDS(256), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns just after the accepting posedge.
  task automatic send(input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits for the response (rsp_ready held high), compares against the scoreboard.
  task automatic recv(input string tag);
    int n = 0;
    logic [32:0] e;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    chk({tag, "_latency"}, 64'(n - 1), 64'd2);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
      chk({tag, "_rdata"}, {32'd0, rsp_rdata}, {32'd0, e[31:0]});
      chk({tag, "_err"}, {63'd0, rsp_err}, {63'd0, e[32]});
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_drop"}, {63'd0, rsp_valid}, 64'd0);
  endtask

  task automatic issue(input string tag, input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input bit exp_e);
    exp_q.push_back({exp_e, exp_d});
    send(we, size, uns, addr, wd);
    recv(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] e;
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rst_rsp_err",   {63'd0, rsp_err},   64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

    issue("st_w0",  1, 2'b10, 0, 32'd0, 32'h11223344, 32'h0, 0);
    issue("ld_w0",  0, 2'b10, 0, 32'd0, 32'h0, 32'h11223344, 0);

    // Byte stores fill the word from the MSB lane downwards; upper wdata bits are ignored.
    issue("clr_w0", 1, 2'b10, 0, 32'd0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      issue("st_b",   1, 2'b00, 0, 32'(i), 32'hABCDEFFF, 32'h0, 0);
      issue("ld_acc", 0, 2'b10, 0, 32'd0, 32'h0, ~(32'hFFFFFFFF >> (8 * (i + 1))), 0);
    end

    issue("st_w4",   1, 2'b10, 0, 32'd4, 32'h80FF7F01, 32'h0, 0);
    issue("ld_bs4",  0, 2'b00, 0, 32'd4, 32'h0, 32'hFFFFFF80, 0);
    issue("ld_bu4",  0, 2'b00, 1, 32'd4, 32'h0, 32'h00000080, 0);
    issue("ld_hs6",  0, 2'b01, 0, 32'd6, 32'h0, 32'h00007F01, 0);
    issue("ld_hs4",  0, 2'b01, 0, 32'd4, 32'h0, 32'hFFFF80FF, 0);
    issue("ld_hu4",  0, 2'b01, 1, 32'd4, 32'h0, 32'h000080FF, 0);
    issue("ld_bu5",  0, 2'b00, 1, 32'd5, 32'h0, 32'h000000FF, 0);
    issue("ld_bs7",  0, 2'b00, 0, 32'd7, 32'h0, 32'h00000001, 0);
    issue("ld_wu4",  0, 2'b10, 1, 32'd4, 32'h0, 32'h80FF7F01, 0);

    issue("ld_h1_err",  0, 2'b01, 0, 32'd1, 32'h0, 32'h0, 1);
    issue("st_w2_err",  1, 2'b10, 0, 32'd2, 32'h55555555, 32'h0, 1);
    issue("ld_w0_kept", 0, 2'b10, 0, 32'd0, 32'h0, 32'hFFFFFFFF, 0);
    issue("rsvd_err",   0, 2'b11, 0, 32'd0, 32'h0, 32'h0, 1);
    issue("range_err",  1, 2'b10, 0, 32'd1024, 32'h12121212, 32'h0, 1);
    issue("range_ld",   0, 2'b00, 0, 32'd1027, 32'h0, 32'h0, 1);
    issue("st_last",    1, 2'b10, 0, 32'd1020, 32'h0A0B0C0D, 32'h0, 0);
    issue("ld_last",    0, 2'b10, 0, 32'd1020, 32'h0, 32'h0A0B0C0D, 0);
    issue("ld_w0_wrap", 0, 2'b10, 0, 32'd0, 32'h0, 32'hFFFFFFFF, 0);
    issue("st_h2",      1, 2'b01, 0, 32'd2, 32'h1234CAFE, 32'h0, 0);
    issue("ld_h2_word", 0, 2'b10, 0, 32'd0, 32'h0, 32'hFFFFCAFE, 0);

    // Backpressure: response must hold and req_ready stay low until the consumer accepts.
    rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h80FF7F01});
    send(0, 2'b10, 0, 32'd4, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    e = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",     {63'd0, rsp_valid}, 64'd1);
      chk("bp_rdata",     {32'd0, rsp_rdata}, {32'd0, e[31:0]});
      chk("bp_err",       {63'd0, rsp_err},   {63'd0, e[32]});
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    e = exp_q.pop_front();
    chk("bp_final_rdata", {32'd0, rsp_rdata}, {32'd0, e[31:0]});
    @(posedge clk);
    @(negedge clk);
    chk("bp_done_valid",     {63'd0, rsp_valid}, 64'd0);
    chk("bp_done_req_ready", {63'd0, req_ready}, 64'd1);

    // Reset during ACCESS of a store must suppress the write.
    issue("st_w8", 1, 2'b10, 0, 32'd8, 32'h12345678, 32'h0, 0);
    send(1, 2'b10, 0, 32'd8, 32'hDEADBEEF);
    rst = 1'b1;
    @(negedge clk);
    chk("rsta_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rsta_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rsta_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rsta_rsp_err",   {63'd0, rsp_err},   64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rsta_after_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rsta_after_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    issue("ld_w8_kept", 0, 2'b10, 0, 32'd8, 32'h0, 32'h12345678, 0);

    // Reset during RESP drops the response.
    send(0, 2'b10, 0, 32'd8, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstr_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rstr_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstr_no_rsp", {63'd0, rsp_valid}, 64'd0);
    issue("ld_w8_again", 0, 2'b10, 0, 32'd8, 32'h0, 32'h12345678, 0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
